// File: rtl/ss_seq_pkg.sv
// Shared save-state definitions: sequencer state encoding and default mapper address map.
package ss_seq_pkg;

    localparam int unsigned ADDR_W        = 8;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DEF_LAST_ADDR = 15;
    localparam int unsigned DEF_IDX_ADDR  = 127;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAVE   = 3'd1,
        S_CHK_RD = 3'd2,
        S_CHK    = 3'd3,
        S_LD_RD  = 3'd4,
        S_LD_WR  = 3'd5,
        S_FIN    = 3'd6
    } ss_state_e;

endpackage

// File: rtl/ss_seq_if.sv
// Bundle of the control, mapper save-state and state-buffer signals around the sequencer.
interface ss_seq_if;
    import ss_seq_pkg::*;

    // start_save/start_load are single-cycle requests, accepted only while busy is low;
    // each accepted request ends with exactly one done pulse unless reset intervenes.
    logic              start_save;
    logic              start_load;
    logic              busy;
    logic              done;
    logic              err;
    logic              ss_act;
    logic              ss_we;
    logic [ADDR_W-1:0] ss_addr;
    logic [DATA_W-1:0] ss_wdat;
    logic [DATA_W-1:0] ss_rdat;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_we;
    logic [DATA_W-1:0] buf_wdat;
    logic [DATA_W-1:0] buf_rdat;

    modport master (
        input  start_save, start_load, ss_rdat, buf_rdat,
        output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

    modport slave (
        output start_save, start_load, ss_rdat, buf_rdat,
        input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

endinterface

// File: rtl/ss_seq.sv
// Save-state sequencer: copies mapper registers into a buffer, or restores them after
// verifying the buffer was captured from the same mapper (index register match).
module ss_seq
    import ss_seq_pkg::*;
#(
    parameter int unsigned LAST_ADDR = DEF_LAST_ADDR,
    parameter int unsigned IDX_ADDR  = DEF_IDX_ADDR
) (
    input  logic      clk,
    input  logic      rst_n,
    ss_seq_if.master  bus,
    output ss_state_e dbg_state
);

    if (LAST_ADDR >= IDX_ADDR || IDX_ADDR > 255) begin : g_bad_params
        $error("ss_seq: LAST_ADDR must be below IDX_ADDR and both must fit in 8 bits");
    end

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] IDX_A  = ADDR_W'(IDX_ADDR);

    ss_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              act_q, act_d;
    logic              we_q, we_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] ss_addr_q, ss_addr_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] ss_wdat_q, ss_wdat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            act_q      <= 1'b0;
            we_q       <= 1'b0;
            buf_we_q   <= 1'b0;
            ss_addr_q  <= '0;
            buf_addr_q <= '0;
            ss_wdat_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            act_q      <= act_d;
            we_q       <= we_d;
            buf_we_q   <= buf_we_d;
            ss_addr_q  <= ss_addr_d;
            buf_addr_q <= buf_addr_d;
            ss_wdat_q  <= ss_wdat_d;
        end
    end

    // Outputs are computed for the state being entered so that every output is a flop.
    // The buffer address runs one step ahead during a load so that the registered
    // write data is already valid in the LD_WR cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = err_q;
        we_d       = 1'b0;
        buf_we_d   = 1'b0;
        ss_addr_d  = ss_addr_q;
        buf_addr_d = buf_addr_q;
        ss_wdat_d  = ss_wdat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_save) begin
                    state_d    = S_SAVE;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    ss_addr_d  = IDX_A;
                    buf_addr_d = IDX_A;
                    buf_we_d   = 1'b1;
                end else if (bus.start_load) begin
                    state_d    = S_CHK_RD;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    ss_addr_d  = IDX_A;
                    buf_addr_d = IDX_A;
                end
            end
            S_SAVE: begin
                if (ss_addr_q == IDX_A) begin
                    ss_addr_d  = '0;
                    buf_addr_d = '0;
                    buf_we_d   = 1'b1;
                end else if (cnt_q == LAST_A) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                    ss_addr_d  = cnt_q + 8'd1;
                    buf_addr_d = cnt_q + 8'd1;
                    buf_we_d   = 1'b1;
                end
            end
            S_CHK_RD: begin
                state_d    = S_CHK;
                buf_addr_d = '0;
            end
            S_CHK: begin
                if (bus.buf_rdat == bus.ss_rdat) begin
                    state_d   = S_LD_RD;
                    ss_addr_d = '0;
                end else begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_LD_RD: begin
                state_d   = S_LD_WR;
                we_d      = 1'b1;
                ss_wdat_d = bus.buf_rdat;
                if (cnt_q != LAST_A) begin
                    buf_addr_d = cnt_q + 8'd1;
                end
            end
            S_LD_WR: begin
                if (cnt_q == LAST_A) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_LD_RD;
                    cnt_d     = cnt_q + 8'd1;
                    ss_addr_d = cnt_q + 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d inside {S_SAVE, S_CHK_RD, S_CHK, S_LD_RD, S_LD_WR});
        act_d  = busy_d;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ss_act   = act_q;
    assign bus.ss_we    = we_q;
    assign bus.ss_addr  = ss_addr_q;
    assign bus.ss_wdat  = ss_wdat_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_wdat = bus.ss_rdat;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ss_seq.sv
// Directed bench for ss_seq with a behavioural mapper (regs 0..15, index 0x41) and buffer.
module tb_ss_seq;
    import ss_seq_pkg::*;

    logic      clk;
    logic      rst_n;
    ss_state_e dbg_state;
    ss_seq_if  bus();

    ss_seq #(.LAST_ADDR(15), .IDX_ADDR(127)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- mapper and buffer models ----------------
    logic [7:0] map_regs [0:15];
    logic [7:0] buf_mem  [0:255];
    logic       init_map_req, init_buf_req, clr_req;
    logic [7:0] init_buf_idx, init_buf_base;
    int         we_cnt;
    logic       idx_wr, act_gap;
    logic [7:0] map_rdat;

    always_comb begin
        map_rdat = 8'h00;
        if (bus.ss_addr == 8'd127) map_rdat = 8'h41;
        else if (bus.ss_addr < 8'd16) map_rdat = map_regs[bus.ss_addr[3:0]];
    end
    assign bus.ss_rdat = map_rdat;

    always @(posedge clk) begin
        if (init_map_req) begin
            for (int i = 0; i < 16; i++) map_regs[i] <= 8'h10 + 8'(i);
        end else if (bus.ss_we && bus.ss_addr < 8'd16) begin
            map_regs[bus.ss_addr[3:0]] <= bus.ss_wdat;
        end
        if (init_buf_req) begin
            for (int i = 0; i < 256; i++)
                buf_mem[i] <= (i < 16) ? init_buf_base + 8'(i) : ((i == 127) ? init_buf_idx : 8'h00);
        end else if (bus.buf_we) begin
            buf_mem[bus.buf_addr] <= bus.buf_wdat;
        end
        bus.buf_rdat <= buf_mem[bus.buf_addr];
        if (clr_req) begin
            we_cnt  <= 0;
            idx_wr  <= 1'b0;
            act_gap <= 1'b0;
        end else begin
            if (bus.ss_we) we_cnt <= we_cnt + 1;
            if (bus.ss_we && bus.ss_addr == 8'd127) idx_wr <= 1'b1;
            if (bus.ss_act !== bus.busy) act_gap <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic prefill(input logic im, input logic ib, input logic [7:0] idx, input logic [7:0] base);
        @(negedge clk);
        init_map_req  = im;
        init_buf_req  = ib;
        init_buf_idx  = idx;
        init_buf_base = base;
        clr_req       = 1'b1;
        @(negedge clk);
        init_map_req = 1'b0;
        init_buf_req = 1'b0;
        clr_req      = 1'b0;
    endtask

    // Pulses the requested starts, then samples once per cycle until done (bounded).
    // inj_at >= 0 pulses start_load at that sample index while the sequence runs.
    task automatic run_seq(input logic sv, input logic ld, input int inj_at,
                           output int busy_cycles, output logic got_done);
        @(negedge clk);
        bus.start_save = sv;
        bus.start_load = ld;
        @(negedge clk);
        bus.start_save = 1'b0;
        bus.start_load = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) got_done = 1'b1;
            else begin
                bus.start_load = (i == inj_at);
                @(negedge clk);
                bus.start_load = 1'b0;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic check_mem(input string tag, input logic [7:0] map_base,
                             input logic [7:0] buf_idx, input logic [7:0] buf_base);
        for (int k = 0; k < 16; k++) begin
            check({tag, "_map"}, 32'(map_regs[k]), 32'(map_base + 8'(k)));
            check({tag, "_buf"}, 32'(buf_mem[k]), 32'(buf_base + 8'(k)));
        end
        check({tag, "_buf_idx"}, 32'(buf_mem[127]), 32'(buf_idx));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] op;         // 1 save, 2 load, 3 both starts together
        logic       init_map;
        logic       init_buf;
        logic [7:0] buf_idx;
        logic [7:0] buf_base;
        int         exp_busy;
        logic       exp_err;
        int         exp_we;
        logic [7:0] exp_map_base;
        logic [7:0] exp_buf_idx;
        logic [7:0] exp_buf_base;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int   bc;
        logic gd;

        vecs[0] = '{2'd1, 1'b1, 1'b1, 8'h00, 8'h00, 17, 1'b0, 0,  8'h10, 8'h41, 8'h10};
        vecs[1] = '{2'd2, 1'b0, 1'b1, 8'h41, 8'hA0, 34, 1'b0, 16, 8'hA0, 8'h41, 8'hA0};
        vecs[2] = '{2'd2, 1'b0, 1'b1, 8'h42, 8'h55, 2,  1'b1, 0,  8'hA0, 8'h42, 8'h55};
        vecs[3] = '{2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 17, 1'b0, 0,  8'hA0, 8'h41, 8'hA0};
        vecs[4] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 34, 1'b0, 16, 8'hA0, 8'h41, 8'hA0};

        rst_n          = 1'b0;
        bus.start_save = 1'b0;
        bus.start_load = 1'b0;
        init_map_req   = 1'b0;
        init_buf_req   = 1'b0;
        clr_req        = 1'b1;
        init_buf_idx   = 8'h00;
        init_buf_base  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_act", 32'(bus.ss_act), 32'd0);
        check("rst_we", 32'(bus.ss_we), 32'd0);
        check("rst_buf_we", 32'(bus.buf_we), 32'd0);
        check("rst_ss_addr", 32'(bus.ss_addr), 32'd0);
        check("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("rst_ss_wdat", 32'(bus.ss_wdat), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n   = 1'b1;
        clr_req = 1'b0;

        for (int v = 0; v < 5; v++) begin
            prefill(vecs[v].init_map, vecs[v].init_buf, vecs[v].buf_idx, vecs[v].buf_base);
            run_seq(vecs[v].op[0], vecs[v].op[1], -1, bc, gd);
            check($sformatf("v%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_busy));
            check($sformatf("v%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", v), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_idle", v), 32'(dbg_state), 32'(S_IDLE));
            check($sformatf("v%0d_err_sticky", v), 32'(bus.err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_we_pulses", v), 32'(we_cnt), 32'(vecs[v].exp_we));
            check($sformatf("v%0d_idx_written", v), 32'(idx_wr), 32'd0);
            check($sformatf("v%0d_act_gap", v), 32'(act_gap), 32'd0);
            check_mem($sformatf("v%0d", v), vecs[v].exp_map_base, vecs[v].exp_buf_idx,
                      vecs[v].exp_buf_base);
        end

        // start_load pulsed mid-save must be dropped, not queued behind the save
        prefill(1'b1, 1'b1, 8'h00, 8'h00);
        run_seq(1'b1, 1'b0, 4, bc, gd);
        check("inj_busy_cycles", 32'(bc), 32'd17);
        repeat (2) begin
            @(negedge clk);
            check("inj_not_queued", 32'(bus.busy), 32'd0);
        end
        check("inj_we_pulses", 32'(we_cnt), 32'd0);
        check_mem("inj", 8'h10, 8'h41, 8'h10);

        // asynchronous reset in load cycle 10
        prefill(1'b1, 1'b1, 8'h41, 8'hA0);
        @(negedge clk);
        bus.start_load = 1'b1;
        @(negedge clk);
        bus.start_load = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_act", 32'(bus.ss_act), 32'd0);
        check("arst_we", 32'(bus.ss_we), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_ss_addr", 32'(bus.ss_addr), 32'd0);
        check("arst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("arst_ss_wdat", 32'(bus.ss_wdat), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", 32'(bus.done), 32'd0);
        end
        prefill(1'b1, 1'b1, 8'h00, 8'h00);
        run_seq(1'b1, 1'b0, -1, bc, gd);
        check("post_rst_busy", 32'(bc), 32'd17);
        @(negedge clk);
        check_mem("post_rst", 8'h10, 8'h41, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
